serial_adder_unit: RTL and testbench

- Bit-serial ripple adder: LSB-first, one sum bit per clock through a single full-adder cell and a carry flip-flop.
- Inverse companion of the bit-serial subtractor datapath: adding the subtrahend back to a difference recovers the minuend.
- Adds a start/busy/done handshake and registered parallel result, so control logic can sequence it without hand-generated clocks.

---
 rtl/serial_arith_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_unit.sv | 127 ++++++++++++
 tb/tb_serial_adder_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic units.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational one-bit full-adder cell used by the serial adder datapath.
module full_adder (
    input  logic X,
    input  logic Y,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = X ^ Y ^ Cin;
    assign Cout = (X & Y) | (X & Cin) | (Y & Cin);

endmodule

// File: rtl/serial_adder_unit.sv
// LSB-first bit-serial adder with start/busy/done handshake and registered result.
// Optional SERIAL_ADDER_SUB_EN adds a Mode input selecting Augend-Addend.
module serial_adder_unit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             St,
    input  logic [WIDTH-1:0] Augend,
    input  logic [WIDTH-1:0] Addend,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Mode,
`endif
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] acc_sr_r;
    logic [WIDTH-1:0] add_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             y_s;
    logic             carry_init_s;
    logic             s_s;
    logic             cout_s;

`ifdef SERIAL_ADDER_SUB_EN
    logic             mode_r;

    // Subtraction feeds the inverted addend bit and starts with carry-in 1.
    assign y_s          = add_sr_r[0] ^ mode_r;
    assign carry_init_s = Mode;
`else
    assign y_s          = add_sr_r[0];
    assign carry_init_s = 1'b0;
`endif

    full_adder u_full_adder (
        .X    (acc_sr_r[0]),
        .Y    (y_s),
        .Cin  (carry_r),
        .S    (s_s),
        .Cout (cout_s)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // Operation mode register, captured together with the operands.
    always_ff @(posedge CLK) begin
        if (R) begin
            mode_r <= 1'b0;
        end else if ((state_r == IDLE) && St) begin
            mode_r <= Mode;
        end else begin
            mode_r <= mode_r;
        end
    end
`endif

    // Control FSM, shift registers, carry flip-flop and registered outputs.
    always_ff @(posedge CLK) begin
        if (R) begin
            state_r  <= IDLE;
            acc_sr_r <= {WIDTH{1'b0}};
            add_sr_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            Sum      <= {WIDTH{1'b0}};
            Cout     <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    Done <= 1'b0;
                    if (St) begin
                        acc_sr_r <= Augend;
                        add_sr_r <= Addend;
                        carry_r  <= carry_init_s;
                        cnt_r    <= {CW{1'b0}};
                        Busy     <= 1'b1;
                        state_r  <= SHIFT;
                    end else begin
                        Busy     <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_sr_r <= {s_s, acc_sr_r[WIDTH-1:1]};
                    add_sr_r <= {1'b0, add_sr_r[WIDTH-1:1]};
                    carry_r  <= cout_s;
                    cnt_r    <= cnt_r + CW'(1'b1);
                    // Last bit: the shifted accumulator is the complete sum.
                    if (cnt_r == CNT_LAST) begin
                        Sum     <= {s_s, acc_sr_r[WIDTH-1:1]};
                        Cout    <= cout_s;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        Busy    <= 1'b1;
                        Done    <= 1'b0;
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Randomized self-checking bench for serial_adder_unit against an arithmetic reference model.
module tb_serial_adder_unit;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         R = 1'b1;
    logic         St = 1'b0;
    logic [W-1:0] Augend = '0;
    logic [W-1:0] Addend = '0;
    logic         Mode = 1'b0;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int failures = 0;

    serial_adder_unit #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .R      (R),
        .St     (St),
        .Augend (Augend),
        .Addend (Addend),
`ifdef SERIAL_ADDER_SUB_EN
        .Mode   (Mode),
`endif
        .Sum    (Sum),
        .Cout   (Cout),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {carry, sum} of a+b, or a-b with carry meaning no borrow.
    function automatic logic [W:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        if (m) begin
            r = ai - bi + (1 << W);
        end else begin
            r = ai + bi;
        end
        return (W+1)'(r);
    endfunction

    // Behavioural model: a phase count since acceptance, result published at completion.
    int           m_phase = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_a, m_b, m_sum;
    logic         m_mode, m_cout;
    logic [W:0]   m_res;

    always @(posedge CLK) begin
        if (R) begin
            m_valid = 1'b1;
            m_phase = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
        end else if (m_phase == 0) begin
            if (St) begin
                m_a     = Augend;
                m_b     = Addend;
`ifdef SERIAL_ADDER_SUB_EN
                m_mode  = Mode;
`else
                m_mode  = 1'b0;
`endif
                m_phase = 1;
            end
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == W + 1) begin
                m_res  = ref_calc(m_a, m_b, m_mode);
                m_sum  = m_res[W-1:0];
                m_cout = m_res[W];
            end else if (m_phase == W + 2) begin
                m_phase = 0;
            end
        end
    end

    int cyc = 0;
    int last_done = -1;
    bit held_mode = 1'b0;
    int held_pulses = 0;

    // Per-cycle comparison of every output against the model, plus pulse spacing.
    always @(negedge CLK) begin
        cyc++;
        if (m_valid) begin
            chk("busy", 32'(Busy), 32'(m_phase >= 1 && m_phase <= W));
            chk("done", 32'(Done), 32'(m_phase == W + 1));
            chk("sum",  32'(Sum),  32'(m_sum));
            chk("cout", 32'(Cout), 32'(m_cout));
            if (held_mode && Done) begin
                if (last_done >= 0) begin
                    chk("held_spacing", 32'(cyc - last_done), 32'(W + 2));
                end
                last_done = cyc;
                held_pulses++;
            end
        end
    end

    // Launch one operation and check latency, busy length and literal result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input string name);
        int k, busy_cnt;
        bit seen;
        @(negedge CLK);
        Augend = a;
        Addend = b;
        Mode   = m;
        St     = 1'b1;
        @(negedge CLK);
        St       = 1'b0;
        Augend   = W'($urandom);
        Addend   = W'($urandom);
        k        = 1;
        busy_cnt = int'(Busy);
        seen     = 1'b0;
        while (!seen && k < 40) begin
            if (Done) begin
                seen = 1'b1;
            end else begin
                @(negedge CLK);
                k++;
                busy_cnt += int'(Busy);
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(k), 32'(W + 1));
        chk({name, "_busy_len"}, 32'(busy_cnt), 32'(W));
        chk({name, "_sum"}, 32'(Sum), 32'(exp_sum));
        chk({name, "_cout"}, 32'(Cout), 32'(exp_cout));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rm;
        logic [W:0]   rr;
        int           dcount;

        repeat (2) @(negedge CLK);
        R = 1'b0;
        @(negedge CLK);
        chk("reset_sum", 32'(Sum), 32'd0);
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);

        run_op(8'h22, 8'h83, 1'b0, 8'hA5, 1'b0, "add_22_83");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "add_00_00");
        run_op(8'h22, 8'h83, 1'b0, 8'hA5, 1'b0, "add_again");

        // Abort in the middle of the shift phase.
        @(negedge CLK);
        Augend = 8'h22;
        Addend = 8'h83;
        Mode   = 1'b0;
        St     = 1'b1;
        @(negedge CLK);
        St = 1'b0;
        repeat (3) @(negedge CLK);
        R = 1'b1;
        @(negedge CLK);
        R = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_sum", 32'(Sum), 32'd0);
        chk("abort_cout", 32'(Cout), 32'd0);
        dcount = 0;
        for (int i = 0; i < W + 6; i++) begin
            @(negedge CLK);
            dcount += int'(Done);
        end
        chk("abort_no_done", 32'(dcount), 32'd0);

        // Start held high, operands changing every cycle.
        held_mode = 1'b1;
        St = 1'b1;
        for (int i = 0; i < 6 * (W + 2); i++) begin
            Augend = W'($urandom);
            Addend = W'($urandom);
            @(negedge CLK);
        end
        St = 1'b0;
        repeat (W + 3) @(negedge CLK);
        held_mode = 1'b0;
        chk("held_pulse_count", 32'(held_pulses >= 5), 32'd1);

        // Randomized operations, expected result from reference arithmetic.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rm = 1'($urandom_range(1, 0));
`else
            rm = 1'b0;
`endif
            rr = ref_calc(ra, rb, rm);
            run_op(ra, rb, rm, rr[W-1:0], rr[W], "rand");
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'hA5, 8'h83, 1'b1, 8'h22, 1'b1, "sub_a5_83");
        run_op(8'h83, 8'hA5, 1'b1, 8'hDE, 1'b0, "sub_83_a5");
        run_op(8'h22, 8'h83, 1'b0, 8'hA5, 1'b0, "mode0_22_83");
`endif

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
